// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: line sync/filter, 11-bit frame decode with timeout, show-ahead byte FIFO.
// Define PS2_PREFIX_DECODE_EN to fold 0xE0/0xF0 prefixes into per-entry rx_ext/rx_release flags.
module ps2_host_rx #(
    parameter int unsigned FILTER    = 4,
    parameter int unsigned TIMEOUT   = 20000,
    parameter int unsigned FIFO_BITS = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       rx_ext,
    output logic       rx_release,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int unsigned FLT_W = 4;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DEPTH = 1 << FIFO_BITS;
    localparam int unsigned PTR_W = FIFO_BITS + 1;
`ifdef PS2_PREFIX_DECODE_EN
    localparam int unsigned ENT_W = 10;
`else
    localparam int unsigned ENT_W = 8;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_filt_q, data_filt_q, clk_prev_q;
    logic [FLT_W-1:0] clk_fcnt_q, data_fcnt_q;
    logic             fall_c;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovf_q, ovf_d;
    logic            good_c, par_ok_c;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ENT_W-1:0] entry_c, head_c;
    logic             push_c, pop_c, full_c, wr_en_c;

    // Two-flop synchronisers for both lines
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Level filters: a new level must persist FILTER samples before it is accepted
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_fcnt_q  <= '0;
            data_fcnt_q <= '0;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_prev_q <= clk_filt_q;
            if (clk_sync_q[1] == clk_filt_q) begin
                clk_fcnt_q <= '0;
            end else if (clk_fcnt_q == FLT_W'(FILTER - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                clk_fcnt_q <= '0;
            end else begin
                clk_fcnt_q <= clk_fcnt_q + FLT_W'(1);
            end
            if (data_sync_q[1] == data_filt_q) begin
                data_fcnt_q <= '0;
            end else if (data_fcnt_q == FLT_W'(FILTER - 1)) begin
                data_filt_q <= data_sync_q[1];
                data_fcnt_q <= '0;
            end else begin
                data_fcnt_q <= data_fcnt_q + FLT_W'(1);
            end
        end
    end

    assign fall_c   = clk_prev_q & ~clk_filt_q;
    assign par_ok_c = ^{shreg_q, par_q};

    // Frame decoder: advances on filtered clock falls, aborts on a stalled frame
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        good_c    = 1'b0;
        if (state_q == IDLE || fall_c) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (fall_c) begin
            case (state_q)
                IDLE: begin
                    if (!data_filt_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {data_filt_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'(1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_filt_q;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!data_filt_q) begin
                        ferr_d = 1'b1;
                    end else if (par_ok_c) begin
                        good_c = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic pend_ext_q, pend_ext_d;
    logic pend_rel_q, pend_rel_d;

    // Prefixes are absorbed into pending flags before the FIFO full check
    always_comb begin
        pend_ext_d = pend_ext_q;
        pend_rel_d = pend_rel_q;
        push_c     = 1'b0;
        entry_c    = {pend_ext_q, pend_rel_q, shreg_q};
        if (perr_d || ferr_d) begin
            pend_ext_d = 1'b0;
            pend_rel_d = 1'b0;
        end else if (good_c) begin
            if (shreg_q == 8'hE0) begin
                pend_ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                pend_rel_d = 1'b1;
            end else begin
                push_c     = 1'b1;
                pend_ext_d = 1'b0;
                pend_rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_ext_q <= 1'b0;
            pend_rel_q <= 1'b0;
        end else begin
            pend_ext_q <= pend_ext_d;
            pend_rel_q <= pend_rel_d;
        end
    end

    assign rx_ext     = rx_valid & head_c[9];
    assign rx_release = rx_valid & head_c[8];
`else
    always_comb begin
        push_c  = good_c;
        entry_c = shreg_q;
    end

    assign rx_ext     = 1'b0;
    assign rx_release = 1'b0;
`endif

    // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        pop_c   = rx_valid & rx_rd;
        full_c  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                  (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
        wr_en_c = push_c & (~full_c | pop_c);
        ovf_d   = push_c & full_c & ~pop_c;
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= entry_c;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign head_c     = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign rx_valid   = (wr_ptr_q != rd_ptr_q);
    assign rx_data    = rx_valid ? head_c[7:0] : 8'h00;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboard bench for ps2_host_rx: directed PS/2 frames, expected entries queued at issue time,
// a negedge monitor checks every popped entry and counts error/overflow pulse cycles.
module tb_ps2_host_rx;
    localparam int unsigned FILTER    = 4;
    localparam int unsigned TIMEOUT   = 20000;
    localparam int unsigned FIFO_BITS = 2;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned HALF      = 100;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_rd    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ext, rx_release;
    logic       parity_err, frame_err, overflow;

    ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_rd      (rx_rd),
        .rx_ext     (rx_ext),
        .rx_release (rx_release),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    logic [9:0] exp_q[$];
    int n_cmp = 0, n_err = 0;
    int perr_seen = 0, ferr_seen = 0, ovf_seen = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    logic pend_ext = 1'b0, pend_rel = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pulse-cycle counters and scoreboard compare on every accepted pop
    always @(negedge clk_sys) begin
        if (parity_err) perr_seen++;
        if (frame_err)  ferr_seen++;
        if (overflow)   ovf_seen++;
        if (!reset && rx_rd && rx_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h, want no entry", {rx_ext, rx_release, rx_data});
            end else begin
                check("pop_entry", int'({rx_ext, rx_release, rx_data}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_exp(input logic [9:0] e);
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(e);
    endtask

    task automatic expect_good(input logic [7:0] d);
`ifdef PS2_PREFIX_DECODE_EN
        if (d == 8'hE0) pend_ext = 1'b1;
        else if (d == 8'hF0) pend_rel = 1'b1;
        else begin
            push_exp({pend_ext, pend_rel, d});
            pend_ext = 1'b0;
            pend_rel = 1'b0;
        end
`else
        push_exp({2'b00, d});
`endif
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit pop_at_fall);
        ps2_data = b;
        if (glitch) begin
            tick(HALF / 2);
            ps2_clk = 1'b0;
            tick(2);
            ps2_clk = 1'b1;
            tick(HALF - HALF / 2 - 2);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            // Filtered fall is processed 7 edges after the raw fall; pop on that same edge
            tick(6);
            rx_rd = 1'b1;
            tick(1);
            rx_rd = 1'b0;
            tick(HALF - 7);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit pop_stop);
        logic p;
        p = (~^d) ^ logic'(bad_par);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch && (i == 4), 1'b0);
        send_bit(p, 1'b0, 1'b0);
        send_bit(logic'(!bad_stop), 1'b0, pop_stop);
        ps2_data = 1'b1;
        tick(20);
        if (bad_stop) begin
            exp_ferr++;
            pend_ext = 1'b0;
            pend_rel = 1'b0;
        end else if (bad_par) begin
            exp_perr++;
            pend_ext = 1'b0;
            pend_rel = 1'b0;
        end else begin
            expect_good(d);
        end
    endtask

    task automatic send_partial();
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'(i[0]), 1'b0, 1'b0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_perr"}, perr_seen, exp_perr);
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
        check({tag, "_ovf"}, ovf_seen, exp_ovf);
        check({tag, "_valid"}, int'(rx_valid), int'(exp_q.size() != 0));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            if (!rx_valid) break;
            rx_rd = 1'b1;
            tick(1);
            rx_rd = 1'b0;
            tick(1);
        end
        check({tag, "_drain_valid"}, int'(rx_valid), 0);
        check({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    initial begin
        tick(5);
        reset = 1'b0;
        tick(2);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_flags", int'({rx_ext, rx_release}), 0);
        check("rst_pulses", perr_seen + ferr_seen + ovf_seen, 0);

        // Single good byte, then one read empties the FIFO
        send_frame(8'h1C, 0, 0, 0, 0);
        check_status("t1");
        check("t1_head", int'(rx_data), 'h1C);
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
        check("t1_after_pop", int'(rx_valid), 0);

        // Bad parity drops the byte; next good byte arrives
        send_frame(8'h1C, 1, 0, 0, 0);
        check_status("t2a");
        send_frame(8'h5A, 0, 0, 0, 0);
        check_status("t2b");
        check("t2_head", int'(rx_data), 'h5A);
        drain("t2");

        // Bad stop bit, then a frame with a short clock glitch
        send_frame(8'h29, 0, 1, 0, 0);
        check_status("t3a");
        send_frame(8'h29, 0, 0, 1, 0);
        check_status("t3b");
        check("t3_head", int'(rx_data), 'h29);
        drain("t3");

        // Stalled frame times out once; decoder recovers
        send_partial();
        tick(TIMEOUT + 100);
        exp_ferr++;
        pend_ext = 1'b0;
        pend_rel = 1'b0;
        check_status("t4a");
        send_frame(8'h76, 0, 0, 0, 0);
        check_status("t4b");
        check("t4_head", int'(rx_data), 'h76);
        drain("t4");

        // Reset mid-frame discards silently
        send_partial();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        pend_ext = 1'b0;
        pend_rel = 1'b0;
        tick(20);
        check_status("trst");

        // Overflow on the fifth byte, then push+pop while full
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0, 0);
        check_status("t5a");
        check("t5_head", int'(rx_data), 'h01);
        drain("t5a");
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 0, 0, 0);
        send_frame(8'h15, 0, 0, 0, 1);
        check_status("t5b");
        check("t5_head_b", int'(rx_data), 'h12);
        drain("t5b");

        // Prefix handling
        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0, 0);
        check_status("t6a");
`ifdef PS2_PREFIX_DECODE_EN
        check("t6a_head", int'({rx_ext, rx_release, rx_data}), 'h375);
`else
        check("t6a_head", int'({rx_ext, rx_release, rx_data}), 'h0E0);
`endif
        drain("t6a");
        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'h33, 1, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0, 0);
        check_status("t6b");
`ifdef PS2_PREFIX_DECODE_EN
        check("t6b_head", int'({rx_ext, rx_release, rx_data}), 'h075);
`else
        check("t6b_head", int'({rx_ext, rx_release, rx_data}), 'h0E0);
`endif
        drain("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
